port_latch: RTL

PORT_LATCH -- requirements
Module: port_latch

---
 rtl/port_latch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/port_latch.sv
// Port data latches, per-pin synchronizers and file-register read/write access
// for PORTA/B/C, with sticky change detection on PORTB[7:4].
`ifndef IO_A_WIDTH
`define IO_A_WIDTH 4
`endif
`ifndef IO_B_WIDTH
`define IO_B_WIDTH 8
`endif
`ifndef IO_C_WIDTH
`define IO_C_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module port_latch #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              fileAddr,
    input  logic                    wrStrobe,
    input  logic                    rdStrobe,
    input  logic [`DATA_WIDTH-1:0]  wrData,
    input  logic                    rbWakeEn,
    input  logic [`IO_A_WIDTH-1:0]  padA,
    input  logic [`IO_B_WIDTH-1:0]  padB,
    input  logic [`IO_C_WIDTH-1:0]  padC,
    output logic [`IO_A_WIDTH-1:0]  portAOut,
    output logic [`IO_B_WIDTH-1:0]  portBOut,
    output logic [`IO_C_WIDTH-1:0]  portCOut,
    output logic [`DATA_WIDTH-1:0]  rdData,
    output logic                    rdValid,
    output logic                    rbChange
);

    localparam int unsigned A_W    = `IO_A_WIDTH;
    localparam int unsigned B_W    = `IO_B_WIDTH;
    localparam int unsigned C_W    = `IO_C_WIDTH;
    localparam int unsigned DATA_W = `DATA_WIDTH;
    localparam int unsigned RB_W   = 4;

    localparam logic [4:0] ADDR_PORTA = 5'h05;
    localparam logic [4:0] ADDR_PORTB = 5'h06;
    localparam logic [4:0] ADDR_PORTC = 5'h07;

    logic [A_W-1:0] stgA [SYNC_STAGES];
    logic [B_W-1:0] stgB [SYNC_STAGES];
    logic [C_W-1:0] stgC [SYNC_STAGES];

    logic [A_W-1:0] syncA;
    logic [B_W-1:0] syncB;
    logic [C_W-1:0] syncC;

    logic              hitA_c;
    logic              hitB_c;
    logic              hitC_c;
    logic [DATA_W-1:0] rdMux_c;
    logic              rbRead_c;
    logic              rbMismatch_c;

    logic [RB_W-1:0] rbRef;
    logic            rbArmed;

    // Pin synchronizer chains; stage 0 samples the pad, last stage feeds logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stgA[i] <= '0;
                stgB[i] <= '0;
                stgC[i] <= '0;
            end
        end else begin
            stgA[0] <= padA;
            stgB[0] <= padB;
            stgC[0] <= padC;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stgA[i] <= stgA[i-1];
                stgB[i] <= stgB[i-1];
                stgC[i] <= stgC[i-1];
            end
        end
    end

    assign syncA = stgA[SYNC_STAGES-1];
    assign syncB = stgB[SYNC_STAGES-1];
    assign syncC = stgC[SYNC_STAGES-1];

    always_comb begin
        hitA_c  = 1'b0;
        hitB_c  = 1'b0;
        hitC_c  = 1'b0;
        rdMux_c = '0;
        case (fileAddr)
            ADDR_PORTA: begin
                hitA_c  = 1'b1;
                rdMux_c = DATA_W'(syncA);
            end
            ADDR_PORTB: begin
                hitB_c  = 1'b1;
                rdMux_c = DATA_W'(syncB);
            end
            ADDR_PORTC: begin
                hitC_c  = 1'b1;
                rdMux_c = DATA_W'(syncC);
            end
            default: ;
        endcase
    end

    assign rbRead_c     = rdStrobe && hitB_c;
    assign rbMismatch_c = syncB[B_W-1 -: RB_W] != rbRef;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            portAOut <= '0;
            portBOut <= '0;
            portCOut <= '0;
        end else if (wrStrobe) begin
            if (hitA_c) portAOut <= A_W'(wrData);
            if (hitB_c) portBOut <= B_W'(wrData);
            if (hitC_c) portCOut <= C_W'(wrData);
        end
    end

    // Reads always sample the pins, never the latches; misses return zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdData  <= '0;
            rdValid <= 1'b0;
        end else begin
            rdValid <= rdStrobe;
            if (rdStrobe) rdData <= rdMux_c;
        end
    end

    // A PORTB read re-arms and clears; it takes priority over a same-cycle mismatch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rbRef    <= '0;
            rbArmed  <= 1'b0;
            rbChange <= 1'b0;
        end else if (rbRead_c) begin
            rbRef    <= syncB[B_W-1 -: RB_W];
            rbArmed  <= 1'b1;
            rbChange <= 1'b0;
        end else if (rbWakeEn && rbArmed && rbMismatch_c) begin
            rbChange <= 1'b1;
        end
    end

endmodule
